// File: rtl/fft_addr_counter.sv
// Butterfly index / pass sequencer for the FFT datapath; FFT_ADDR_BITREV_EN adds a bit-reversed index.
// Latency: every output is registered and changes one edge after the sampled start/enable/clear.
// Backpressure: enable low freezes all state; start is ignored while a run is active.
module fft_addr_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16,
    parameter int STAGES  = 4
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic                                          enable,
    input  logic                                          clear,
    output logic [WIDTH-1:0]                              count,
    output logic [WIDTH-1:0]                              count_rev,
    output logic [((STAGES > 1) ? $clog2(STAGES) : 1)-1:0] stage,
    output logic                                          wrap,
    output logic                                          done,
    output logic                                          busy,
    output logic                                          overflow
);

    localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;

    // Terminal values of the index and pass counters, compared at native width.
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(MODULUS - 1);
    localparam logic [SW-1:0]    STG_LAST = SW'(STAGES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    // Next-state logic: clear beats start, start beats enable.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        stage_d = stage_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = IDLE;
            count_d = '0;
            stage_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        count_d = '0;
                        stage_d = '0;
                        ovf_d   = 1'b0;
                    end
                end
                RUN: begin
                    if (enable) begin
                        if (count_q == CNT_LAST) begin
                            count_d = '0;
                            wrap_d  = 1'b1;
                            if (stage_q == STG_LAST) begin
                                stage_d = '0;
                                state_d = IDLE;
                                done_d  = 1'b1;
                                ovf_d   = 1'b1;
                            end else begin
                                stage_d = stage_q + SW'(1);
                            end
                        end else begin
                            count_d = count_q + WIDTH'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            stage_q <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            stage_q <= stage_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef FFT_ADDR_BITREV_EN
    logic [WIDTH-1:0] rev_q, rev_d;

    // Mirror the next index so the reversed copy lands on the same edge as count.
    always_comb begin
        rev_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rev_d[i] = count_d[WIDTH-1-i];
        end
    end

    // Reversed-index register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rev_q <= '0;
        end else begin
            rev_q <= rev_d;
        end
    end

    assign count_rev = rev_q;
`else
    assign count_rev = '0;
`endif

    assign count    = count_q;
    assign stage    = stage_q;
    assign wrap     = wrap_q;
    assign done     = done_q;
    assign busy     = (state_q == RUN);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_fft_addr_counter.sv
// Bench for fft_addr_counter: two instances (16x4 and 12x3) driven by shared controls.
// Expected outputs are pushed to a scoreboard queue per step and popped after the edge.
// Directed checks cover wrap timing, done timing, clear, async reset and bit reversal.
module tb_fft_addr_counter;

    logic       clk = 1'b0;
    logic       reset, start, enable, clear;
    logic [3:0] cnt0, rev0, cnt1, rev1;
    logic [1:0] stg0, stg1;
    logic       wrap0, done0, busy0, ovf0;
    logic       wrap1, done1, busy1, ovf1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft_addr_counter #(.WIDTH(4), .MODULUS(16), .STAGES(4)) dut0 (
        .clk(clk), .reset(reset), .start(start), .enable(enable), .clear(clear),
        .count(cnt0), .count_rev(rev0), .stage(stg0), .wrap(wrap0), .done(done0),
        .busy(busy0), .overflow(ovf0)
    );

    fft_addr_counter #(.WIDTH(4), .MODULUS(12), .STAGES(3)) dut1 (
        .clk(clk), .reset(reset), .start(start), .enable(enable), .clear(clear),
        .count(cnt1), .count_rev(rev1), .stage(stg1), .wrap(wrap1), .done(done1),
        .busy(busy1), .overflow(ovf1)
    );

    typedef struct {
        int cnt;
        int rev;
        int stg;
        int wrap;
        int done;
        int busy;
        int ovf;
    } exp_t;

    exp_t sbq[$];

    int m_cnt [2];
    int m_stg [2];
    int m_run [2];
    int m_wrap[2];
    int m_done[2];
    int m_ovf [2];
    int m_mod [2] = '{16, 12};
    int m_stgs[2] = '{4, 3};

    function automatic int bitrev4(input int v);
`ifdef FFT_ADDR_BITREV_EN
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) r = r | (1 << (3 - i));
        end
        return r;
`else
        return v * 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_stg[k] = 0; m_run[k] = 0;
            m_wrap[k] = 0; m_done[k] = 0; m_ovf[k] = 0;
        end
    endtask

    // Behavioural reference for one clock edge, then push expectations.
    task automatic model_edge(input bit st, input bit en, input bit cl);
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            m_wrap[k] = 0;
            m_done[k] = 0;
            if (cl) begin
                m_run[k] = 0; m_cnt[k] = 0; m_stg[k] = 0; m_ovf[k] = 0;
            end else if (m_run[k] == 0) begin
                if (st) begin
                    m_run[k] = 1; m_cnt[k] = 0; m_stg[k] = 0; m_ovf[k] = 0;
                end
            end else if (en) begin
                if (m_cnt[k] == m_mod[k] - 1) begin
                    m_cnt[k]  = 0;
                    m_wrap[k] = 1;
                    if (m_stg[k] == m_stgs[k] - 1) begin
                        m_stg[k] = 0; m_run[k] = 0; m_done[k] = 1; m_ovf[k] = 1;
                    end else begin
                        m_stg[k] = m_stg[k] + 1;
                    end
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end
            e.cnt = m_cnt[k]; e.rev = bitrev4(m_cnt[k]); e.stg = m_stg[k];
            e.wrap = m_wrap[k]; e.done = m_done[k]; e.busy = m_run[k]; e.ovf = m_ovf[k];
            sbq.push_back(e);
        end
    endtask

    task automatic compare_outputs();
        exp_t e;
        e = sbq.pop_front();
        chk("d0_count", 32'(cnt0), e.cnt);
        chk("d0_rev", 32'(rev0), e.rev);
        chk("d0_stage", 32'(stg0), e.stg);
        chk("d0_wrap", 32'(wrap0), e.wrap);
        chk("d0_done", 32'(done0), e.done);
        chk("d0_busy", 32'(busy0), e.busy);
        chk("d0_ovf", 32'(ovf0), e.ovf);
        e = sbq.pop_front();
        chk("d1_count", 32'(cnt1), e.cnt);
        chk("d1_rev", 32'(rev1), e.rev);
        chk("d1_stage", 32'(stg1), e.stg);
        chk("d1_wrap", 32'(wrap1), e.wrap);
        chk("d1_done", 32'(done1), e.done);
        chk("d1_busy", 32'(busy1), e.busy);
        chk("d1_ovf", 32'(ovf1), e.ovf);
    endtask

    // Drive one cycle of controls, predict, clock, then sample away from the edge.
    task automatic step(input bit st, input bit en, input bit cl);
        start = st; enable = en; clear = cl;
        model_edge(st, en, cl);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cnt0"}, 32'(cnt0), 0);
        chk({tag, "_stg0"}, 32'(stg0), 0);
        chk({tag, "_busy0"}, 32'(busy0), 0);
        chk({tag, "_ovf0"}, 32'(ovf0), 0);
        chk({tag, "_done0"}, 32'(done0), 0);
        chk({tag, "_wrap0"}, 32'(wrap0), 0);
        chk({tag, "_rev0"}, 32'(rev0), 0);
        chk({tag, "_cnt1"}, 32'(cnt1), 0);
        chk({tag, "_busy1"}, 32'(busy1), 0);
    endtask

    initial begin
        int wraps_at[$];
        int done0_at, done1_at, max_cnt1, guard;

        // Reset held with start and enable active.
        reset = 1'b0; start = 1'b1; enable = 1'b1; clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        start = 1'b0; enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Start: busy with index and pass at zero.
        step(1, 0, 0);
        chk("start_busy", 32'(busy0), 1);
        chk("start_count", 32'(cnt0), 0);

        // Full run with enable held.
        done0_at = -1; done1_at = -1; max_cnt1 = 0;
        for (int i = 1; i <= 64; i++) begin
            step(0, 1, 0);
            if (wrap0) wraps_at.push_back(i);
            if (done0) done0_at = i;
            if (done1) done1_at = i;
            if (int'(cnt1) > max_cnt1) max_cnt1 = int'(cnt1);
        end
        chk("wrap_pulses", wraps_at.size(), 4);
        for (int j = 0; j < 4; j++) begin
            chk("wrap_cycle", (j < wraps_at.size()) ? wraps_at[j] : -1, 16 * (j + 1));
        end
        chk("done16_cycle", done0_at, 64);
        chk("done12_cycle", done1_at, 36);
        chk("max_count12", max_cnt1, 11);
        chk("after_run_busy", 32'(busy0), 0);
        chk("after_run_ovf", 32'(ovf0), 1);

        // Start accepted in the cycle done is high; overflow cleared.
        step(1, 1, 0);
        chk("restart_ovf", 32'(ovf0), 0);

        // Enable gaps, then a start that must not restart the run.
        for (int i = 0; i < 10; i++) step(0, bit'(i % 2), 0);
        step(1, 1, 0);
        chk("ignored_start_count", 32'(cnt0), 6);

        // Advance to index 7 of pass 2, then clear.
        guard = 0;
        while (!(m_cnt[0] == 7 && m_stg[0] == 2) && guard < 200) begin
            step(0, 1, 0);
            guard++;
        end
        chk("reach_7_2", guard < 200, 1);
        step(0, 0, 1);
        chk("clear_busy", 32'(busy0), 0);
        chk("clear_done", 32'(done0), 0);
        chk("clear_count", 32'(cnt0), 0);

        // Clear and start together: stays idle.
        step(1, 0, 1);
        chk("clear_start_busy", 32'(busy0), 0);

        // Asynchronous reset mid-cycle at index 9.
        step(1, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 0);
        chk("pre_reset_count", 32'(cnt0), 9);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("async");
        model_reset();
        start = 1'b0; enable = 1'b0; clear = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Bit-reversed index at count 1 and 6.
        step(1, 0, 0);
        step(0, 1, 0);
`ifdef FFT_ADDR_BITREV_EN
        chk("rev_of_1", 32'(rev0), 8);
`else
        chk("rev_of_1", 32'(rev0), 0);
`endif
        for (int i = 0; i < 5; i++) step(0, 1, 0);
        chk("count_6", 32'(cnt0), 6);
`ifdef FFT_ADDR_BITREV_EN
        chk("rev_of_6", 32'(rev0), 6);
`else
        chk("rev_of_6", 32'(rev0), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
